// File: rtl/hwpe_stream_package.sv
// Shared types and constants for the hwpe_stream pipe slices.
// Contents: slice state enum, stage-count limit, occupancy width helper.
// No logic; imported by hwpe_stream_assign_slice and hwpe_stream_assign_pipe.
package hwpe_stream_package;

  localparam int HWPE_STREAM_PIPE_MAX_STAGES = 8;

  typedef enum logic [1:0] {
    SLICE_EMPTY,
    SLICE_HALF,
    SLICE_FULL
  } hwpe_stream_slice_state_t;

  // Width needed to hold 0..2*nb_stages; never narrower than one bit.
  function automatic int pipe_cnt_width(input int nb_stages);
    return (nb_stages == 0) ? 1 : $clog2(2 * nb_stages + 1);
  endfunction

endpackage

// File: rtl/hwpe_stream_assign_slice.sv
// One 2-entry skid register slice: main register drives downstream, skid catches the
// beat in flight when downstream stalls. Latency 1 cycle, full throughput.
// Backpressure: up_rdy is registered (!skid valid), so no combinational ready path.
// Ports: clk_i/rst_i (sync active-high), up_* sink side, dn_* source side,
//        cnt = number of beats held here (0..2).
module hwpe_stream_assign_slice
  import hwpe_stream_package::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    up_vld,
  output logic                    up_rdy,
  input  logic [DATA_WIDTH-1:0]   up_dat,
  input  logic [DATA_WIDTH/8-1:0] up_strb,
  output logic                    dn_vld,
  input  logic                    dn_rdy,
  output logic [DATA_WIDTH-1:0]   dn_dat,
  output logic [DATA_WIDTH/8-1:0] dn_strb,
  output logic [1:0]              cnt
);

  hwpe_stream_slice_state_t state_q;
  logic [DATA_WIDTH-1:0]    main_dat_q, skid_dat_q;
  logic [DATA_WIDTH/8-1:0]  main_strb_q, skid_strb_q;
  logic                     in_hs, out_hs;

  // Ready is a pure function of state; rst_i masks it so nothing is taken during reset.
  assign up_rdy  = (state_q != SLICE_FULL) && !rst_i;
  assign dn_vld  = (state_q != SLICE_EMPTY);
  assign dn_dat  = main_dat_q;
  assign dn_strb = main_strb_q;

  assign in_hs  = up_vld & up_rdy;
  assign out_hs = dn_vld & dn_rdy;

  always_comb begin
    cnt = 2'd0;
    case (state_q)
      SLICE_HALF: cnt = 2'd1;
      SLICE_FULL: cnt = 2'd2;
      default:    cnt = 2'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= SLICE_EMPTY;
      main_dat_q  <= '0;
      main_strb_q <= '0;
      skid_dat_q  <= '0;
      skid_strb_q <= '0;
    end else begin
      case (state_q)
        SLICE_EMPTY: begin
          if (in_hs) begin
            main_dat_q  <= up_dat;
            main_strb_q <= up_strb;
            state_q     <= SLICE_HALF;
          end
        end
        SLICE_HALF: begin
          if (in_hs && out_hs) begin
            // Pass-through with no bubble: new beat replaces the one leaving.
            main_dat_q  <= up_dat;
            main_strb_q <= up_strb;
          end else if (in_hs) begin
            skid_dat_q  <= up_dat;
            skid_strb_q <= up_strb;
            state_q     <= SLICE_FULL;
          end else if (out_hs) begin
            state_q <= SLICE_EMPTY;
          end
        end
        SLICE_FULL: begin
          // up_rdy is low here, so only the skid-to-main move can happen.
          if (out_hs) begin
            main_dat_q  <= skid_dat_q;
            main_strb_q <= skid_strb_q;
            state_q     <= SLICE_HALF;
          end
        end
        default: state_q <= SLICE_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/hwpe_stream_assign_pipe.sv
// Stream connection through NB_STAGES skid slices; NB_STAGES=0 is a plain wire.
// Latency NB_STAGES cycles at 1 beat/cycle; ready registered per slice (NB_STAGES>=1).
// Backpressure: push_rdy drops only when the first slice holds two beats.
// Ports: clk_i/rst_i (sync active-high), push_* sink stream, pop_* source stream,
//        occupancy_o beats held across all slices, empty_o occupancy is zero.
module hwpe_stream_assign_pipe
  import hwpe_stream_package::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NB_STAGES  = 1,
  parameter int CNT_WIDTH  = pipe_cnt_width(NB_STAGES)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_vld,
  output logic                    push_rdy,
  input  logic [DATA_WIDTH-1:0]   push_dat,
  input  logic [DATA_WIDTH/8-1:0] push_strb,
  output logic                    pop_vld,
  input  logic                    pop_rdy,
  output logic [DATA_WIDTH-1:0]   pop_dat,
  output logic [DATA_WIDTH/8-1:0] pop_strb,
  output logic [CNT_WIDTH-1:0]    occupancy_o,
  output logic                    empty_o
);

  if (DATA_WIDTH % 8 != 0) begin : g_err_width
    $error("hwpe_stream_assign_pipe: DATA_WIDTH must be a multiple of 8");
  end
  if (NB_STAGES > HWPE_STREAM_PIPE_MAX_STAGES) begin : g_err_stages
    $error("hwpe_stream_assign_pipe: NB_STAGES exceeds HWPE_STREAM_PIPE_MAX_STAGES");
  end

  if (NB_STAGES == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign pop_vld     = push_vld;
    assign pop_dat     = push_dat;
    assign pop_strb    = push_strb;
    assign push_rdy    = pop_rdy;
    assign occupancy_o = '0;
    assign empty_o     = 1'b1;
  end else begin : g_pipe
    // Index s is the input of slice s; index NB_STAGES is the pipe output.
    logic                    vld  [NB_STAGES+1];
    logic                    rdy  [NB_STAGES+1];
    logic [DATA_WIDTH-1:0]   dat  [NB_STAGES+1];
    logic [DATA_WIDTH/8-1:0] strb [NB_STAGES+1];
    logic [1:0]              cnt  [NB_STAGES];
    logic [CNT_WIDTH-1:0]    occ;

    assign vld[0]           = push_vld;
    assign dat[0]           = push_dat;
    assign strb[0]          = push_strb;
    assign push_rdy         = rdy[0];
    assign pop_vld          = vld[NB_STAGES];
    assign pop_dat          = dat[NB_STAGES];
    assign pop_strb         = strb[NB_STAGES];
    assign rdy[NB_STAGES]   = pop_rdy;

    for (genvar s = 0; s < NB_STAGES; s++) begin : g_slice
      hwpe_stream_assign_slice #(
        .DATA_WIDTH(DATA_WIDTH)
      ) i_slice (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .up_vld (vld[s]),
        .up_rdy (rdy[s]),
        .up_dat (dat[s]),
        .up_strb(strb[s]),
        .dn_vld (vld[s+1]),
        .dn_rdy (rdy[s+1]),
        .dn_dat (dat[s+1]),
        .dn_strb(strb[s+1]),
        .cnt    (cnt[s])
      );
    end

    always_comb begin
      occ = '0;
      for (int s = 0; s < NB_STAGES; s++) begin
        occ = occ + CNT_WIDTH'(cnt[s]);
      end
    end

    assign occupancy_o = occ;
    assign empty_o     = (occ == '0);
  end

endmodule

// File: tb/tb_hwpe_stream_assign_pipe.sv
// Bench for hwpe_stream_assign_pipe: five instances with NB_STAGES 0,1,2,3,8.
// Inputs driven 1 time unit after the rising edge; outputs sampled there or at the falling edge.
// Backpressure and random traffic are scoreboarded per instance.
module tb_hwpe_stream_assign_pipe;

  localparam int NDUT = 5;

  function automatic int nb_of(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      2:       return 2;
      3:       return 3;
      default: return 8;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        push_vld  [NDUT];
  logic        push_rdy  [NDUT];
  logic [31:0] push_dat  [NDUT];
  logic [3:0]  push_strb [NDUT];
  logic        pop_vld   [NDUT];
  logic        pop_rdy   [NDUT];
  logic [31:0] pop_dat   [NDUT];
  logic [3:0]  pop_strb  [NDUT];
  logic [4:0]  occ       [NDUT];
  logic        empty     [NDUT];

  int checks = 0;
  int passed = 0;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int NB = nb_of(k);
    localparam int CW = (NB == 0) ? 1 : $clog2(2 * NB + 1);
    logic [CW-1:0] occ_l;
    hwpe_stream_assign_pipe #(
      .DATA_WIDTH(32),
      .NB_STAGES (NB),
      .CNT_WIDTH (CW)
    ) i_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .push_vld   (push_vld[k]),
      .push_rdy   (push_rdy[k]),
      .push_dat   (push_dat[k]),
      .push_strb  (push_strb[k]),
      .pop_vld    (pop_vld[k]),
      .pop_rdy    (pop_rdy[k]),
      .pop_dat    (pop_dat[k]),
      .pop_strb   (pop_strb[k]),
      .occupancy_o(occ_l),
      .empty_o    (empty[k])
    );
    assign occ[k] = 5'(occ_l);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < NDUT; k++) begin
      push_vld[k]  = 1'b0;
      push_dat[k]  = 32'h0;
      push_strb[k] = 4'h0;
      pop_rdy[k]   = 1'b0;
    end
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    push_vld[2] = 1'b1;
    push_dat[2] = 32'hBAD0_BAD0;
    tick();
    tick();
    checks++;
    if (push_rdy[2] !== 1'b0) $display("FAIL reset_rdy_during_rst got %b exp 0", push_rdy[2]);
    else passed++;
    push_vld[2] = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (pop_vld[2] !== 1'b0 || pop_dat[2] !== 32'h0 || pop_strb[2] !== 4'h0)
      $display("FAIL reset_pop got vld=%b dat=%h strb=%h exp 0/0/0", pop_vld[2], pop_dat[2], pop_strb[2]);
    else passed++;
    checks++;
    if (occ[2] !== 5'd0 || empty[2] !== 1'b1)
      $display("FAIL reset_occ got occ=%0d empty=%b exp 0/1", occ[2], empty[2]);
    else passed++;
    checks++;
    if (push_rdy[2] !== 1'b1) $display("FAIL reset_rdy_after got %b exp 1", push_rdy[2]);
    else passed++;
    checks++;
    if (occ[4] !== 5'd0 || empty[4] !== 1'b1 || pop_vld[4] !== 1'b0)
      $display("FAIL reset_nb8 got occ=%0d empty=%b vld=%b exp 0/1/0", occ[4], empty[4], pop_vld[4]);
    else passed++;
  endtask

  task automatic test_streaming();
    pop_rdy[2] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_vld[2] = 1'b1;
      push_dat[2] = 32'(i + 1);
      push_strb[2] = 4'hF;
      tick();
      checks++;
      if (i == 0) begin
        if (pop_vld[2] !== 1'b0 || occ[2] !== 5'd1)
          $display("FAIL stream_latency got vld=%b occ=%0d exp 0/1", pop_vld[2], occ[2]);
        else passed++;
      end else begin
        if (pop_vld[2] !== 1'b1 || pop_dat[2] !== 32'(i) || occ[2] !== 5'd2)
          $display("FAIL stream_beat%0d got vld=%b dat=%h occ=%0d exp 1/%h/2",
                   i, pop_vld[2], pop_dat[2], occ[2], 32'(i));
        else passed++;
      end
    end
    push_vld[2] = 1'b0;
    tick();
    checks++;
    if (pop_vld[2] !== 1'b1 || pop_dat[2] !== 32'h10 || occ[2] !== 5'd1)
      $display("FAIL stream_last got vld=%b dat=%h occ=%0d exp 1/10/1", pop_vld[2], pop_dat[2], occ[2]);
    else passed++;
    tick();
    checks++;
    if (pop_vld[2] !== 1'b0 || occ[2] !== 5'd0 || empty[2] !== 1'b1)
      $display("FAIL stream_drained got vld=%b occ=%0d empty=%b exp 0/0/1", pop_vld[2], occ[2], empty[2]);
    else passed++;
    pop_rdy[2] = 1'b0;
  endtask

  task automatic test_backpressure();
    int accepted;
    accepted = 0;
    pop_rdy[2] = 1'b0;
    push_strb[2] = 4'hA;
    for (int c = 0; c < 6; c++) begin
      push_vld[2] = 1'b1;
      push_dat[2] = 32'h21 + 32'(accepted);
      if (push_rdy[2]) accepted++;
      tick();
    end
    push_vld[2] = 1'b0;
    checks++;
    if (accepted != 4) $display("FAIL bp_accepted got %0d exp 4", accepted);
    else passed++;
    checks++;
    if (push_rdy[2] !== 1'b0 || occ[2] !== 5'd4 || empty[2] !== 1'b0)
      $display("FAIL bp_full got rdy=%b occ=%0d empty=%b exp 0/4/0", push_rdy[2], occ[2], empty[2]);
    else passed++;
    pop_rdy[2] = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pop_vld[2] !== 1'b1 || pop_dat[2] !== 32'h21 + 32'(i) || pop_strb[2] !== 4'hA)
        $display("FAIL bp_drain%0d got vld=%b dat=%h strb=%h exp 1/%h/a",
                 i, pop_vld[2], pop_dat[2], pop_strb[2], 32'h21 + 32'(i));
      else passed++;
      tick();
    end
    checks++;
    if (pop_vld[2] !== 1'b0 || occ[2] !== 5'd0)
      $display("FAIL bp_empty got vld=%b occ=%0d exp 0/0", pop_vld[2], occ[2]);
    else passed++;
    pop_rdy[2] = 1'b0;
  endtask

  task automatic test_passthrough();
    pop_rdy[0] = 1'b0;
    #1;
    checks++;
    if (push_rdy[0] !== 1'b0) $display("FAIL wire_rdy_low got %b exp 0", push_rdy[0]);
    else passed++;
    pop_rdy[0] = 1'b1;
    #1;
    checks++;
    if (push_rdy[0] !== 1'b1) $display("FAIL wire_rdy_high got %b exp 1", push_rdy[0]);
    else passed++;
    push_vld[0]  = 1'b1;
    push_dat[0]  = 32'hDEAD_BEEF;
    push_strb[0] = 4'h5;
    #1;
    checks++;
    if (pop_vld[0] !== 1'b1 || pop_dat[0] !== 32'hDEAD_BEEF || pop_strb[0] !== 4'h5)
      $display("FAIL wire_data got vld=%b dat=%h strb=%h exp 1/deadbeef/5", pop_vld[0], pop_dat[0], pop_strb[0]);
    else passed++;
    tick();
    checks++;
    if (occ[0] !== 5'd0 || empty[0] !== 1'b1)
      $display("FAIL wire_occ got occ=%0d empty=%b exp 0/1", occ[0], empty[0]);
    else passed++;
    push_vld[0] = 1'b0;
    pop_rdy[0]  = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    pop_rdy[3] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (occ[3] == 5'd5) break;
      push_vld[3] = 1'b1;
      push_dat[3] = 32'h100 + 32'(n);
      push_strb[3] = 4'hF;
      if (push_rdy[3]) n++;
      tick();
    end
    push_vld[3] = 1'b0;
    checks++;
    if (occ[3] !== 5'd5) $display("FAIL rstmid_fill got occ=%0d exp 5", occ[3]);
    else passed++;
    pop_rdy[3] = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (pop_vld[3] !== 1'b0 || occ[3] !== 5'd0 || empty[3] !== 1'b1 || push_rdy[3] !== 1'b1)
      $display("FAIL rstmid_after got vld=%b occ=%0d empty=%b rdy=%b exp 0/0/1/1",
               pop_vld[3], occ[3], empty[3], push_rdy[3]);
    else passed++;
    begin
      int stale;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (pop_vld[3] !== 1'b0) stale++;
      end
      checks++;
      if (stale != 0) $display("FAIL rstmid_stale got %0d stale cycles exp 0", stale);
      else passed++;
    end
    pop_rdy[3] = 1'b0;
  endtask

  task automatic test_half_simul();
    pop_rdy[1]   = 1'b0;
    push_vld[1]  = 1'b1;
    push_dat[1]  = 32'h9;
    push_strb[1] = 4'hF;
    tick();
    push_dat[1] = 32'hA;
    pop_rdy[1]  = 1'b1;
    #1;
    checks++;
    if (occ[1] !== 5'd1 || pop_vld[1] !== 1'b1 || pop_dat[1] !== 32'h9)
      $display("FAIL half_before got occ=%0d vld=%b dat=%h exp 1/1/9", occ[1], pop_vld[1], pop_dat[1]);
    else passed++;
    tick();
    push_vld[1] = 1'b0;
    #1;
    checks++;
    if (occ[1] !== 5'd1 || pop_vld[1] !== 1'b1 || pop_dat[1] !== 32'hA)
      $display("FAIL half_after got occ=%0d vld=%b dat=%h exp 1/1/a", occ[1], pop_vld[1], pop_dat[1]);
    else passed++;
    tick();
    checks++;
    if (occ[1] !== 5'd0 || pop_vld[1] !== 1'b0)
      $display("FAIL half_drain got occ=%0d vld=%b exp 0/0", occ[1], pop_vld[1]);
    else passed++;
    pop_rdy[1] = 1'b0;
  endtask

  task automatic test_random(input int k, input int nbeats);
    logic [35:0] q[$];
    logic [35:0] exp_beat;
    int          sent, recv, cyc;
    logic        hold, pushed;
    logic [31:0] hd;
    logic [3:0]  hs;
    sent = 0; recv = 0; cyc = 0; hold = 1'b0;
    hd = 32'h0; hs = 4'h0;
    push_vld[k] = 1'b0;
    pop_rdy[k]  = 1'b0;
    while (recv < nbeats && cyc < 60000) begin
      @(negedge clk);
      pushed = 1'b0;
      if (hold) begin
        checks++;
        if (pop_vld[k] !== 1'b1 || pop_dat[k] !== hd || pop_strb[k] !== hs)
          $display("FAIL rand%0d_stable got vld=%b dat=%h strb=%h exp 1/%h/%h",
                   k, pop_vld[k], pop_dat[k], pop_strb[k], hd, hs);
        else passed++;
      end
      if (push_vld[k] && push_rdy[k]) begin
        q.push_back({push_strb[k], push_dat[k]});
        sent++;
        pushed = 1'b1;
      end
      if (pop_vld[k] && pop_rdy[k]) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL rand%0d_extra got dat=%h exp no beat", k, pop_dat[k]);
        end else begin
          exp_beat = q.pop_front();
          if ({pop_strb[k], pop_dat[k]} !== exp_beat)
            $display("FAIL rand%0d_beat%0d got %h exp %h", k, recv, {pop_strb[k], pop_dat[k]}, exp_beat);
          else passed++;
        end
        recv++;
      end
      hold = pop_vld[k] && !pop_rdy[k];
      hd   = pop_dat[k];
      hs   = pop_strb[k];
      tick();
      if (!push_vld[k] || pushed) begin
        push_vld[k]  = (sent < nbeats) && ($urandom_range(0, 1) == 1);
        push_dat[k]  = $urandom();
        push_strb[k] = 4'($urandom_range(0, 15));
      end
      pop_rdy[k] = ($urandom_range(0, 1) == 1);
      cyc++;
    end
    checks++;
    if (recv != nbeats) $display("FAIL rand%0d_timeout got %0d beats exp %0d", k, recv, nbeats);
    else passed++;
    push_vld[k] = 1'b0;
    pop_rdy[k]  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_streaming();
    test_backpressure();
    test_passthrough();
    test_half_simul();
    test_reset_mid();
    fork
      test_random(1, 10000);
      test_random(3, 10000);
      test_random(4, 10000);
    join
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
